sl_rx_fifo: RTL
===============

# sl_rx_fifo

Parametrised serial-line (SL) word receiver with a first-word-fall-through receive FIFO. It decodes two-wire SL traffic, where a low pulse on the ones line is a 1, a low pulse on the zeroes line is a 0, and both lines low is a stop bit. It checks word length and odd parity, adds an input glitch filter and an inter-bit gap timeout, and buffers up to FIFO_DEPTH words. It sits between the SL line pins and the register/bus interface and replaces the single-word-buffer receiver.

## Interface
- DATA_W, 32: maximum data bits per word (1..32).
- FIFO_DEPTH, 4: receive FIFO depth in words (power of 2, ≥2).
- FILT_LEN, 4: consecutive equal samples needed to change a filtered line level.
- STROB_POS, 3: cycles after a detected bit start at which the bit value is sampled.
- BIT_TMO, 32: maximum cycles from bit start to bit end.
- GAP_TMO, 64: maximum idle cycles between bits inside a word.

Ports:
- clk, input, 1: system clock (16 MHz).
- rst_n, input, 1: reset, asynchronous, active-low.
- sl_zeroes_a, input, 1: async SL zeroes line; idle high.
- sl_ones_a, input, 1: async SL ones line; idle high.
- cfg_len, input, 6: data bits per word, valid range 1..DATA_W.
- cfg_par_en, input, 1: a parity bit follows the data bits.
- cfg_wr, input, 1: one-cycle config write strobe.
- rd_en, input, 1: pop the FIFO head.
- rd_data, output, DATA_W: FIFO head, zero-extended above cfg_len.
- rd_valid, output, 1: FIFO not empty.
- fifo_cnt, output, $clog2(FIFO_DEPTH+1): number of words held.
- busy, output, 1: a word is in progress (bit count > 0 or decoder not IDLE).
- err_flags, output, 4: sticky errors [0] LEN, [1] PAR, [2] LEV, [3] OVF.
- err_clr, input, 4: write-1-to-clear for err_flags.
- irq, output, 1: rd_valid OR any err_flags bit.

## Operation
- Input path: 2-flop synchroniser per line, then a filter. The filtered level changes only after FILT_LEN consecutive samples at the new value.
- Bit start: filtered falling edge on either line while in IDLE.
- Decoder FSM:
  - IDLE → STROBE on bit start; cycle counter cleared to 0.
  - STROBE: when the counter equals STROB_POS, sample the filtered lines.
    - ones low, zeroes high: data 1.
    - zeroes low, ones high: data 0.
    - both low: stop bit.
    - both high: LEV error.
  - After a data or stop bit → WAIT_END.
  - WAIT_END → IDLE when both filtered lines are high. If the counter reaches BIT_TMO first: LEV error, then → IDLE via ABORT.
  - ABORT: clears the shift register, bit count and parity; → IDLE in 1 cycle. All errors pass through ABORT.
- Data bits arrive LSB first and fill the shift register from bit 0. The bit count saturates at 63.
- Expected bit count is cfg_len + cfg_par_en. Parity is odd over data plus parity bit: the count of 1s must be odd.
- At a stop bit:
  - Count ≠ expected: LEN error.
  - Else, parity enabled and parity wrong: PAR error.
  - Else the word is pushed; if the FIFO is full without a same-cycle pop, the word is dropped and OVF is set.
  - The parity bit is never stored.
  - A stop bit with count 0 is ignored (no error).
- Gap timeout: in IDLE with bit count > 0, the gap counter increments each cycle. At GAP_TMO the word is discarded with a LEN error.
- Config:
  - Writes with cfg_len = 0 or cfg_len > DATA_W are ignored.
  - A valid cfg_wr while busy is held pending and applied on the first cycle busy is low. A later valid write overwrites a pending one.
  - Reset config: len = 32 clipped to DATA_W, parity enabled.
- Error flags: set has priority over err_clr in the same cycle.

## Timing
- Reset values: rd_data 0, rd_valid 0, fifo_cnt 0, busy 0, err_flags 0, irq 0, FSM in IDLE. Filtered lines and synchronisers reset to 1.
- Input-to-start latency: 2 (synchroniser) + FILT_LEN cycles.
- Push: rd_valid and fifo_cnt update on the clock edge after the stop-bit strobe cycle.
- Pop: rd_en with rd_valid high advances rd_data and decrements fifo_cnt on the next edge. rd_en while empty is ignored.
- Push and pop in the same cycle leaves fifo_cnt unchanged, including when full; no OVF is raised.
- Error flags set on the edge after the detecting cycle. irq is combinational from the registered flags and rd_valid.
- Reset asserted mid-word: immediate return to reset values; FIFO contents are lost.

## Test plan
- Config len 8, parity on; send 0xA5 LSB-first, parity bit 1, stop → rd_data 0x000000A5, fifo_cnt 1, err_flags 0.
- Same word with parity bit 0 → err_flags 4'b0010, fifo_cnt 0. Write err_clr 4'b0010 → flags 0.
- Send 5 valid 8-bit words with no reads (FIFO_DEPTH 4) → fifo_cnt 4, OVF set, first four words read back in order.
- Hold the ones line low for 40 cycles (above BIT_TMO) → LEV set, FSM back in IDLE, next word decodes correctly.
- Send 3 bits, then idle for 70 cycles → LEN set, busy drops; a following full word is accepted.
- Pulse cfg_wr with len 16 mid-word → current 8-bit word completes at len 8; next word is decoded as 16 bits. A 2-cycle glitch on a line → no bit detected.

Source files
------------

// File: rtl/sl_rx_fifo.sv
// SL two-wire word receiver: synchroniser + glitch filter, bit decoder with
// length/odd-parity checks and timeouts, feeding a first-word-fall-through FIFO.
module sl_rx_fifo #(
    parameter int DATA_W     = 32,
    parameter int FIFO_DEPTH = 4,
    parameter int FILT_LEN   = 4,
    parameter int STROB_POS  = 3,
    parameter int BIT_TMO    = 32,
    parameter int GAP_TMO    = 64
) (
    input  logic                              clk,
    input  logic                              rst_n,
    input  logic                              sl_zeroes_a,
    input  logic                              sl_ones_a,
    input  logic [5:0]                        cfg_len,
    input  logic                              cfg_par_en,
    input  logic                              cfg_wr,
    input  logic                              rd_en,
    output logic [DATA_W-1:0]                 rd_data,
    output logic                              rd_valid,
    output logic [$clog2(FIFO_DEPTH+1)-1:0]   fifo_cnt,
    output logic                              busy,
    output logic [3:0]                        err_flags,
    input  logic [3:0]                        err_clr,
    output logic                              irq
);
    localparam int CNT_W = $clog2(FIFO_DEPTH + 1);
    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int FW    = $clog2(FILT_LEN + 1);
    localparam int TW    = 16;
    localparam logic [5:0] RST_LEN = (DATA_W < 32) ? 6'(DATA_W) : 6'd32;

    typedef enum logic [1:0] {IDLE, STROBE, WAIT_END, ABORT} state_t;

    logic z_s1_q, z_s2_q, o_s1_q, o_s2_q;
    logic z_filt_q, z_filt_d, o_filt_q, o_filt_d, z_prev_q, o_prev_q;
    logic [FW-1:0] z_fcnt_q, z_fcnt_d, o_fcnt_q, o_fcnt_d;
    state_t state_q, state_d;
    logic [TW-1:0] cyc_q, cyc_d, gap_q, gap_d;
    logic [DATA_W-1:0] shift_q, shift_d;
    logic [5:0] bcnt_q, bcnt_d;
    logic par_q, par_d;
    logic [5:0] len_q, len_d, pend_len_q, pend_len_d;
    logic cfg_par_q, cfg_par_d, pend_par_q, pend_par_d, pend_q, pend_d;
    logic [3:0] err_q, err_d, err_set;
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] fcnt_q, fcnt_d;
    logic [DATA_W-1:0] mem_q [FIFO_DEPTH];
    logic push, pop, wr_en, full, start, cfg_ok, bit_val;
    logic [6:0] exp_cnt;

    // A level change is accepted only after FILT_LEN consecutive new samples.
    always_comb begin
        z_filt_d = z_filt_q;
        z_fcnt_d = '0;
        if (z_s2_q != z_filt_q) begin
            if (z_fcnt_q == FW'(FILT_LEN - 1)) z_filt_d = z_s2_q;
            else z_fcnt_d = z_fcnt_q + 1'b1;
        end
        o_filt_d = o_filt_q;
        o_fcnt_d = '0;
        if (o_s2_q != o_filt_q) begin
            if (o_fcnt_q == FW'(FILT_LEN - 1)) o_filt_d = o_s2_q;
            else o_fcnt_d = o_fcnt_q + 1'b1;
        end
    end

    assign busy    = (bcnt_q != 6'd0) || (state_q != IDLE);
    assign start   = (z_prev_q & ~z_filt_q) | (o_prev_q & ~o_filt_q);
    assign exp_cnt = {1'b0, len_q} + {6'd0, cfg_par_q};
    assign bit_val = ~o_filt_q;
    assign full    = (fcnt_q == CNT_W'(FIFO_DEPTH));
    assign pop     = rd_en && (fcnt_q != '0);

    always_comb begin
        state_d = state_q;
        cyc_d   = cyc_q;
        gap_d   = '0;
        shift_d = shift_q;
        bcnt_d  = bcnt_q;
        par_d   = par_q;
        push    = 1'b0;
        err_set = 4'b0000;
        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = STROBE;
                    cyc_d   = '0;
                end else if (bcnt_q != 6'd0) begin
                    if (gap_q >= TW'(GAP_TMO)) begin
                        err_set[0] = 1'b1;
                        state_d    = ABORT;
                    end else begin
                        gap_d = gap_q + 1'b1;
                    end
                end
            end
            STROBE: begin
                cyc_d = cyc_q + 1'b1;
                if (cyc_q == TW'(STROB_POS)) begin
                    state_d = WAIT_END;
                    if (o_filt_q ^ z_filt_q) begin
                        // The parity bit lands at index len and is never stored.
                        if (bit_val && ({1'b0, bcnt_q} < {1'b0, len_q}))
                            shift_d = shift_q | (DATA_W'(1) << bcnt_q);
                        par_d = par_q ^ bit_val;
                        if (bcnt_q != 6'd63) bcnt_d = bcnt_q + 1'b1;
                    end else if (!o_filt_q && !z_filt_q) begin
                        if (bcnt_q == 6'd0) begin
                            state_d = WAIT_END;
                        end else if ({1'b0, bcnt_q} != exp_cnt) begin
                            err_set[0] = 1'b1;
                            state_d    = ABORT;
                        end else if (cfg_par_q && !par_q) begin
                            err_set[1] = 1'b1;
                            state_d    = ABORT;
                        end else begin
                            push    = 1'b1;
                            shift_d = '0;
                            bcnt_d  = '0;
                            par_d   = 1'b0;
                        end
                    end else begin
                        err_set[2] = 1'b1;
                        state_d    = ABORT;
                    end
                end
            end
            WAIT_END: begin
                cyc_d = cyc_q + 1'b1;
                if (o_filt_q && z_filt_q) begin
                    state_d = IDLE;
                end else if (cyc_q >= TW'(BIT_TMO)) begin
                    err_set[2] = 1'b1;
                    state_d    = ABORT;
                end
            end
            default: begin
                shift_d = '0;
                bcnt_d  = '0;
                par_d   = 1'b0;
                state_d = IDLE;
            end
        endcase
        wr_en      = push && (!full || pop);
        err_set[3] = push && full && !pop;
    end

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        fcnt_d   = fcnt_q;
        if (wr_en) wr_ptr_d = wr_ptr_q + 1'b1;
        if (pop) rd_ptr_d = rd_ptr_q + 1'b1;
        if (wr_en && !pop) fcnt_d = fcnt_q + 1'b1;
        else if (!wr_en && pop) fcnt_d = fcnt_q - 1'b1;
        err_d = (err_q & ~err_clr) | err_set;
    end

    // Config changes never land mid-word; the latest valid write wins.
    always_comb begin
        cfg_ok     = (cfg_len != 6'd0) && ({1'b0, cfg_len} <= 7'(DATA_W));
        len_d      = len_q;
        cfg_par_d  = cfg_par_q;
        pend_d     = pend_q;
        pend_len_d = pend_len_q;
        pend_par_d = pend_par_q;
        if (cfg_wr && cfg_ok) begin
            if (busy) begin
                pend_d     = 1'b1;
                pend_len_d = cfg_len;
                pend_par_d = cfg_par_en;
            end else begin
                pend_d    = 1'b0;
                len_d     = cfg_len;
                cfg_par_d = cfg_par_en;
            end
        end else if (pend_q && !busy) begin
            pend_d    = 1'b0;
            len_d     = pend_len_q;
            cfg_par_d = pend_par_q;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            z_s1_q <= 1'b1; z_s2_q <= 1'b1; o_s1_q <= 1'b1; o_s2_q <= 1'b1;
            z_filt_q <= 1'b1; o_filt_q <= 1'b1; z_prev_q <= 1'b1; o_prev_q <= 1'b1;
            z_fcnt_q <= '0; o_fcnt_q <= '0;
            state_q <= IDLE; cyc_q <= '0; gap_q <= '0;
            shift_q <= '0; bcnt_q <= '0; par_q <= 1'b0;
            len_q <= RST_LEN; cfg_par_q <= 1'b1;
            pend_q <= 1'b0; pend_len_q <= RST_LEN; pend_par_q <= 1'b1;
            err_q <= '0; wr_ptr_q <= '0; rd_ptr_q <= '0; fcnt_q <= '0;
        end else begin
            z_s1_q <= sl_zeroes_a; z_s2_q <= z_s1_q;
            o_s1_q <= sl_ones_a;   o_s2_q <= o_s1_q;
            z_filt_q <= z_filt_d; o_filt_q <= o_filt_d;
            z_prev_q <= z_filt_q; o_prev_q <= o_filt_q;
            z_fcnt_q <= z_fcnt_d; o_fcnt_q <= o_fcnt_d;
            state_q <= state_d; cyc_q <= cyc_d; gap_q <= gap_d;
            shift_q <= shift_d; bcnt_q <= bcnt_d; par_q <= par_d;
            len_q <= len_d; cfg_par_q <= cfg_par_d;
            pend_q <= pend_d; pend_len_q <= pend_len_d; pend_par_q <= pend_par_d;
            err_q <= err_d; wr_ptr_q <= wr_ptr_d; rd_ptr_q <= rd_ptr_d; fcnt_q <= fcnt_d;
        end
    end

    always_ff @(posedge clk) begin
        if (wr_en) mem_q[wr_ptr_q] <= shift_q;
    end

    assign rd_valid  = (fcnt_q != '0);
    assign rd_data   = rd_valid ? mem_q[rd_ptr_q] : '0;
    assign fifo_cnt  = fcnt_q;
    assign err_flags = err_q;
    assign irq       = rd_valid | (|err_q);
endmodule
